// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares BRAM port A between two requesters with round-robin arbitration.
//   One transaction runs IDLE -> ACCESS -> CAPTURE -> ACK. The BRAM samples
//   the port at the end of ACCESS. Its registered output is captured in
//   CAPTURE, and the owner's ack pulses for the single ACK cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req/we/addr/wdata0,1  requester side; held stable until ack
//   ack0, ack1            one-cycle completion pulse
//   rdata0, rdata1        read result, held between acks
//   mem_we/addr/data      BRAM port A drive (registered)
//   mem_q                 BRAM port A read data (valid cycle after address edge)
//   busy                  high whenever the FSM is not in IDLE
module bram_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

   state_t            state, state_nx;
   logic              owner, owner_nx;
   logic              last, last_nx;
   logic              op_we, op_we_nx;   // owner's direction; mem_we is already low in CAPTURE
   logic              winner;
   logic              mem_we_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] mem_data_nx;
   logic              ack0_nx, ack1_nx;
   logic [DATA_W-1:0] rdata0_nx, rdata1_nx;
   logic              busy_nx;

   // On a tie the requester that was not served last wins.
   assign winner = (req0 && req1) ? ~last : req1;

   always_comb begin
      state_nx    = state;
      owner_nx    = owner;
      last_nx     = last;
      op_we_nx    = op_we;
      mem_we_nx   = 1'b0;
      mem_addr_nx = mem_addr;
      mem_data_nx = mem_data;
      ack0_nx     = 1'b0;
      ack1_nx     = 1'b0;
      rdata0_nx   = rdata0;
      rdata1_nx   = rdata1;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_nx    = winner;
               last_nx     = winner;
               op_we_nx    = winner ? we1 : we0;
               mem_we_nx   = winner ? we1 : we0;
               mem_addr_nx = winner ? addr1 : addr0;
               mem_data_nx = winner ? wdata1 : wdata0;
               state_nx    = ACCESS;
            end
         end
         ACCESS: begin
            state_nx = CAPTURE;
         end
         CAPTURE: begin
            if (!op_we) begin
               if (owner) rdata1_nx = mem_q;
               else       rdata0_nx = mem_q;
            end
            ack0_nx  = ~owner;
            ack1_nx  = owner;
            state_nx = ACK;
         end
         ACK: begin
            // Return through IDLE so the owner's req is only re-sampled
            // after it has seen ack and had an edge to drop it.
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         op_we    <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         last     <= last_nx;
         op_we    <= op_we_nx;
         mem_we   <= mem_we_nx;
         mem_addr <= mem_addr_nx;
         mem_data <= mem_data_nx;
         ack0     <= ack0_nx;
         ack1     <= ack1_nx;
         rdata0   <= rdata0_nx;
         rdata1   <= rdata1_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Directed bench for bram_port_arbiter with a behavioural 1024x16 BRAM on
//   port A and a scoreboard queue of expected ack results.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [9:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [15:0] rdata0, rdata1;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data;
   logic [15:0] mem_q;
   logic        busy;

   bram_port_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_q(mem_q), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM: synchronous write, registered read-first output.
   logic [15:0] bram [1024];
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_data;
      mem_q <= bram[mem_addr];
   end

   // Write-strobe monitor.
   int          we_cnt = 0;
   logic [9:0]  we_addr = '0;
   logic [15:0] we_data = '0;
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_data;
      end
   end

   typedef struct {
      int          port;
      logic [15:0] data;
   } sb_t;
   sb_t         sb[$];
   logic [15:0] mdl_rd [2];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected rdata after an ack: new data on a read, unchanged on a write.
   task automatic push(input int p, input bit rd, input logic [15:0] v);
      sb_t e;
      if (rd) mdl_rd[p] = v;
      e.port = p;
      e.data = mdl_rd[p];
      sb.push_back(e);
   endtask

   task automatic sb_check(input int p);
      sb_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("ack_port", 32'(p), 32'(e.port));
         chk(p != 0 ? "rdata1" : "rdata0", 32'(p != 0 ? rdata1 : rdata0), 32'(e.data));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"},    32'({ack0, ack1}), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_addr"},   32'(mem_addr), 0);
      chk({tag, "_data"},   32'(mem_data), 0);
      chk({tag, "_rdata"},  {rdata1, rdata0}, 0);
   endtask

   task automatic set_req(input int p, input logic r, input logic w,
                          input logic [9:0] a, input logic [15:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   // Single transaction from an idle arbiter; rexp is the read result.
   task automatic do_req(input int p, input logic w, input logic [9:0] a,
                         input logic [15:0] d, input logic [15:0] rexp);
      int n;
      bit got, other;
      push(p, !w, rexp);
      @(posedge clk); #1;
      set_req(p, 1'b1, w, a, d);
      n = 0; got = 0; other = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if ((p == 0 ? ack0 : ack1) === 1'b1) got = 1;
         if ((p == 0 ? ack1 : ack0) === 1'b1) other = 1;
      end
      chk("ack_seen", 32'(got), 1);
      chk("ack_latency", 32'(n), 4);
      chk("other_ack", 32'(other), 0);
      sb_check(p);
      @(posedge clk); #1;
      set_req(p, 1'b0, w, a, d);
      @(negedge clk);
      chk("ack_pulse_width", 32'({ack0, ack1}), 0);
      chk("busy_idle", 32'(busy), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      mdl_rd[0] = '0; mdl_rd[1] = '0;
   endtask

   initial begin
      int base, n, t, last_t, p;
      bit got, spurious;
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      mdl_rd[0] = '0; mdl_rd[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1; rst = 1'b0;

      // Write 0x00A5 to addr 3 from requester 0.
      base = we_cnt;
      do_req(0, 1'b1, 10'd3, 16'h00A5, 16'h0000);
      chk("wr_we_cycles", 32'(we_cnt - base), 1);
      chk("wr_addr", 32'(we_addr), 3);
      chk("wr_data", 32'(we_data), 32'h00A5);

      // Requester 1 reads it back; no write strobe.
      base = we_cnt;
      do_req(1, 1'b0, 10'd3, 16'h0000, 16'h00A5);
      chk("rd_no_we", 32'(we_cnt - base), 0);

      // Preload addr 1/2 for the fairness test.
      do_req(0, 1'b1, 10'd1, 16'h0002, 16'h0000);
      do_req(1, 1'b1, 10'd2, 16'h0003, 16'h0000);

      // Both requesters held high right after reset: grants 0,1,0,1.
      pulse_reset();
      push(0, 1'b1, 16'h0002); push(1, 1'b1, 16'h0003);
      push(0, 1'b1, 16'h0002); push(1, 1'b1, 16'h0003);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 10'd1, '0);
      set_req(1, 1'b1, 1'b0, 10'd2, '0);
      t = 0; last_t = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0; got = 0;
         while (!got && n < 20) begin
            @(negedge clk); n++; t++;
            if (ack0 === 1'b1 || ack1 === 1'b1) got = 1;
         end
         chk("fair_ack_seen", 32'(got), 1);
         chk("fair_dual_ack", 32'(ack0 & ack1), 0);
         p = (ack1 === 1'b1) ? 1 : 0;
         chk("grant_order", 32'(p), 32'(k % 2));
         sb_check(p);
         if (k > 0) chk("ack_spacing", 32'(t - last_t), 4);
         last_t = t;
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("fair_end_idle", 32'({busy, ack0, ack1}), 0);

      // Top address, no wrap.
      do_req(1, 1'b1, 10'd1023, 16'hFFFF, 16'h0000);
      chk("top_wr_addr", 32'(we_addr), 32'h3FF);
      do_req(0, 1'b0, 10'd1023, 16'h0000, 16'hFFFF);

      // Reset during CAPTURE of a read: no ack, outputs return to reset.
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 10'd2, '0);
      @(posedge clk);            // IDLE -> ACCESS
      @(posedge clk); #1;        // now in CAPTURE
      rst = 1'b1;
      @(negedge clk);
      chk("cap_no_ack_yet", 32'(ack0), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0);
      mdl_rd[0] = '0; mdl_rd[1] = '0;
      @(negedge clk);
      chk_reset_vals("cap_rst");
      spurious = 0;
      repeat (5) begin @(negedge clk); if (ack0 === 1'b1 || ack1 === 1'b1) spurious = 1; end
      chk("cap_rst_no_ack", 32'(spurious), 0);
      do_req(0, 1'b0, 10'd2, 16'h0000, 16'h0003);

      // Reset on the edge ending ACCESS of a write: write lands, no ack.
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b1, 10'd7, 16'h1234);
      @(posedge clk); #1;        // in ACCESS
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("acc_we_high", 32'(mem_we), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      mdl_rd[0] = '0; mdl_rd[1] = '0;
      @(negedge clk);
      chk_reset_vals("acc_rst");
      spurious = 0;
      repeat (5) begin @(negedge clk); if (ack0 === 1'b1 || ack1 === 1'b1) spurious = 1; end
      chk("acc_rst_no_ack", 32'(spurious), 0);
      do_req(1, 1'b0, 10'd7, 16'h0000, 16'h1234);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
